data_memory_dumper: RTL and testbench
=====================================

# data_memory_dumper

Debug-side reader that, on command, walks the entire byte-addressed data memory and streams its contents byte by byte to the UART transmitter. It sits directly downstream of the data memory's read port and upstream of the UART TX. It is used while the CPU is halted so that the host can inspect memory state after a program run. It owns the memory read controls for the duration of a dump; the debug unit muxes them in place of the pipeline's MEM-stage controls while `o_busy` is high.

## Interface
Parameters:
- `NB_ADDR`, 7: memory address width.
- `NB_DATA`, 32: memory read data width.
- `MEMORY_DEPTH`, 128: bytes in data memory. Must be a multiple of 4 and ≤ 2^NB_ADDR.
- `NB_BYTE`, 8: UART byte width.

Ports:
- `i_clock`  in  1: single clock, rising edge.
- `i_reset_n`  in  1: asynchronous, active-low reset.
- `i_start`  in  1: dump request. Sampled only in IDLE.
- `o_mem_read_flag`  out  1: memory read enable.
- `o_word_en`  out  1: word-mode select. Halfword and byte enables are tied low by the debug unit during a dump.
- `o_address`  out  NB_ADDR: memory byte address, always 4-aligned.
- `i_read_data`  in  NB_DATA: memory read data. Big-endian word: byte at `o_address` sits in [31:24]. Valid one cycle after a read.
- `o_tx_data`  out  NB_BYTE: byte to transmit.
- `o_tx_start`  out  1: one-cycle pulse requesting transmission of `o_tx_data`.
- `i_tx_done`  in  1: one-cycle pulse from UART TX when a byte has finished.
- `o_busy`  out  1: high from leaving IDLE until returning to IDLE.
- `o_done`  out  1: one-cycle pulse after the last byte's `i_tx_done`.

## Operation
- States: IDLE, READ, LATCH, SEND, WAIT, DONE.
- IDLE:
  - `i_start`=1 → address←0, byte_cnt←0, go to READ.
  - Otherwise stay in IDLE.
- READ:
  - `o_mem_read_flag`=1, `o_word_en`=1, `o_address`=address.
  - Next state: LATCH.
- LATCH: word register ← `i_read_data`. Next state: SEND.
- SEND:
  - `o_tx_start`=1 for exactly this cycle.
  - `o_tx_data` = word[31:24], i.e. MSB byte first.
  - Next state: WAIT.
- WAIT:
  - Hold until `i_tx_done`=1, then shift the word left by 8 and byte_cnt←byte_cnt+1.
  - byte_cnt was <3 → SEND.
  - byte_cnt was 3 and address = MEMORY_DEPTH−4 → DONE.
  - byte_cnt was 3, otherwise → address←address+4, byte_cnt←0, READ.
- DONE: `o_done`=1 for one cycle. Next state: IDLE.
- Output order is byte addresses 0,1,2,…,MEMORY_DEPTH−1, ascending.
- `i_start` outside IDLE is ignored, with no queuing.
- `i_tx_done` outside WAIT is ignored.
- Address arithmetic is NB_ADDR bits wide. It never wraps, because termination is checked before the increment.
- `o_tx_data` is held stable from SEND through WAIT.
- `o_mem_read_flag` and `o_word_en` are 0 in every state other than READ.
- `o_address` holds its last value outside READ.

## Timing
- Reset, asynchronous and active-low:
  - State → IDLE.
  - `o_mem_read_flag`, `o_word_en`, `o_tx_start`, `o_busy`, `o_done` = 0.
  - `o_address`, `o_tx_data`, word register, byte_cnt = 0.
- Reset asserted mid-dump aborts immediately, with no further `o_tx_start`. The next dump restarts at address 0.
- `i_start` sampled at edge t → READ during cycle t+1.
- Read latency: data presented in LATCH is captured at the end of that cycle. `o_tx_start` is in the following cycle.
- Per word: READ(1) + LATCH(1) + 4×(SEND(1) + WAIT(L)), where L ≥ 1 is the number of cycles until `i_tx_done` is seen in WAIT.
- Full dump cycles: 1 (IDLE exit) + (MEMORY_DEPTH/4)×(2 + 4×(1+L)) + 1 (DONE).
- `o_busy` is 1 in READ, LATCH, SEND, WAIT and DONE.
- All outputs are registered or decoded from registered state. There is no combinational path from inputs to outputs.

## Test plan
- Reset:
  - Assert `i_reset_n`=0 mid-cycle → all outputs 0 immediately.
  - Release, hold `i_start`=0 for 20 cycles → no read and no `o_tx_start`.
- Single-word order:
  - Memory bytes 0..3 = 0x11,0x22,0x33,0x44. Pulse `i_start`. UART stub gives `i_tx_done` 10 cycles after each start.
  - → First read at address 0. First four `o_tx_data` values are 0x11,0x22,0x33,0x44.
- Full dump:
  - Memory byte i = i for i=0..127. L=1.
  - → 128 `o_tx_start` pulses carrying 0x00..0x7F in order, and 32 read pulses at addresses 0,4,…,124.
  - → `o_done` pulses exactly once. Total cycle count = 1+32×(2+8)+1 = 322.
- Start while busy: pulse `i_start` again at byte 40 → stream is unchanged, with exactly one `o_done`.
- Reset mid-dump:
  - Assert reset after the 50th `o_tx_start` → no further pulses.
  - New `i_start` → stream restarts at byte 0x00.
- Spurious `i_tx_done`: pulse it during READ and SEND → ignored. Byte count and sequence are unaffected.

Source files
------------

// File: rtl/data_memory_dumper_if.sv
// ============================================================================
// Module   : data_memory_dumper_if
// Purpose  : Memory read port and UART TX handshake seen by the memory dumper.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface data_memory_dumper_if #(
    parameter int NB_ADDR = 7,
    parameter int NB_DATA = 32,
    parameter int NB_BYTE = 8
);
    logic               o_mem_read_flag;
    logic               o_word_en;
    logic [NB_ADDR-1:0] o_address;
    logic [NB_DATA-1:0] i_read_data;
    logic [NB_BYTE-1:0] o_tx_data;
    logic               o_tx_start;
    logic               i_tx_done;

    modport master (
        output o_mem_read_flag,
        output o_word_en,
        output o_address,
        input  i_read_data,
        output o_tx_data,
        output o_tx_start,
        input  i_tx_done
    );

    modport slave (
        input  o_mem_read_flag,
        input  o_word_en,
        input  o_address,
        output i_read_data,
        input  o_tx_data,
        input  o_tx_start,
        output i_tx_done
    );
endinterface

`default_nettype wire

// File: rtl/data_memory_dumper.sv
// ============================================================================
// Module   : data_memory_dumper
// Purpose  : Walks the whole data memory word by word and streams it to the
//            UART TX one byte at a time, MSB byte (lowest address) first.
// Revision : 1.0
// ============================================================================
`default_nettype none

module data_memory_dumper #(
    parameter int NB_ADDR      = 7,
    parameter int NB_DATA      = 32,
    parameter int MEMORY_DEPTH = 128,
    parameter int NB_BYTE      = 8
) (
    input  wire logic             i_clock,
    input  wire logic             i_reset_n,
    input  wire logic             i_start,
    data_memory_dumper_if.master  bus,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] READ  = 3'd1;
    localparam logic [2:0] LATCH = 3'd2;
    localparam logic [2:0] SEND  = 3'd3;
    localparam logic [2:0] WAIT  = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(MEMORY_DEPTH - 4);
    localparam logic [NB_ADDR-1:0] ADDR_STEP = NB_ADDR'(4);

    logic [2:0]         state;
    logic [NB_ADDR-1:0] address;
    logic [NB_DATA-1:0] word;
    logic [1:0]         byte_cnt;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state    <= IDLE;
            address  <= '0;
            word     <= '0;
            byte_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        address  <= '0;
                        byte_cnt <= '0;
                        state    <= READ;
                    end
                end
                READ:  state <= LATCH;
                LATCH: begin
                    word  <= bus.i_read_data;
                    state <= SEND;
                end
                SEND:  state <= WAIT;
                WAIT: begin
                    if (bus.i_tx_done) begin
                        word     <= word << NB_BYTE;
                        // 2-bit counter wraps to 0 after the fourth byte
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt != 2'd3) begin
                            state <= SEND;
                        end else if (address == LAST_ADDR) begin
                            state <= DONE;
                        end else begin
                            address <= address + ADDR_STEP;
                            state   <= READ;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode registered state only; no input reaches an output directly.
    assign bus.o_mem_read_flag = (state == READ);
    assign bus.o_word_en       = (state == READ);
    assign bus.o_address       = address;
    assign bus.o_tx_data       = word[NB_DATA-1 -: NB_BYTE];
    assign bus.o_tx_start      = (state == SEND);
    assign o_busy              = (state != IDLE);
    assign o_done              = (state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_data_memory_dumper.sv
// ============================================================================
// Module   : tb_data_memory_dumper
// Purpose  : Directed self-checking bench for data_memory_dumper.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_data_memory_dumper;

    typedef struct {
        int lat;
        bit spur;
        int restart_at;
        int pattern;
        int exp_busy;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic busy;
    logic done;

    logic [7:0]  mem [0:127];
    logic [31:0] rd_data = '0;
    logic        tx_done_q = 1'b0;

    int lat = 1;
    bit spur_en = 1'b0;
    int stub_cnt = 0;

    logic [7:0] tx_q [$];
    logic [6:0] rd_q [$];
    int done_cnt = 0;
    int busy_cycles = 0;
    int checks = 0;
    int errors = 0;

    data_memory_dumper_if #(.NB_ADDR(7), .NB_DATA(32), .NB_BYTE(8)) bus ();

    data_memory_dumper #(
        .NB_ADDR(7), .NB_DATA(32), .MEMORY_DEPTH(128), .NB_BYTE(8)
    ) dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .i_start   (start),
        .bus       (bus),
        .o_busy    (busy),
        .o_done    (done)
    );

    assign bus.i_read_data = rd_data;
    assign bus.i_tx_done   = tx_done_q;

    always #5 clk = ~clk;

    // Synchronous-read memory: data valid the cycle after the read enable
    always @(posedge clk) begin
        if (bus.o_mem_read_flag) begin
            rd_data <= {mem[int'(bus.o_address)],     mem[int'(bus.o_address) + 1],
                        mem[int'(bus.o_address) + 2], mem[int'(bus.o_address) + 3]};
        end
    end

    // Monitor, UART stub (done L cycles after start) and spurious done injector
    always @(negedge clk) begin
        logic nd;
        if (bus.o_tx_start) tx_q.push_back(bus.o_tx_data);
        if (bus.o_mem_read_flag) rd_q.push_back(bus.o_address);
        if (done) done_cnt++;
        if (busy) busy_cycles++;
        if (bus.o_mem_read_flag || bus.o_word_en) begin
            checks++;
            if (bus.o_word_en !== bus.o_mem_read_flag) begin
                errors++;
                $display("FAIL word_en actual=%b required=%b", bus.o_word_en, bus.o_mem_read_flag);
            end
        end
        nd = 1'b0;
        if (!rst_n) begin
            stub_cnt = 0;
        end else begin
            if (stub_cnt > 0) begin
                stub_cnt--;
                if (stub_cnt == 0) nd = 1'b1;
            end
            if (bus.o_tx_start) stub_cnt = lat;
            if (spur_en && (bus.o_mem_read_flag || bus.o_tx_start)) nd = 1'b1;
        end
        tx_done_q = nd;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int p, input int k);
        logic [7:0] kb;
        kb = 8'(k);
        if (p == 1) return kb ^ 8'hA5;
        if (p == 2) begin
            case (k)
                0: return 8'h11;
                1: return 8'h22;
                2: return 8'h33;
                3: return 8'h44;
                default: return kb;
            endcase
        end
        return kb;
    endfunction

    task automatic fill_mem(input int p);
        for (int k = 0; k < 128; k++) mem[k] = pat(p, k);
    endtask

    task automatic clear_mon();
        tx_q.delete();
        rd_q.delete();
        done_cnt = 0;
        busy_cycles = 0;
    endtask

    task automatic start_dump();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int restart_at);
        bit fired;
        int n;
        fired = 1'b0;
        for (n = 0; n < 20000; n++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (restart_at >= 0 && !fired && tx_q.size() == restart_at) begin
                start = 1'b1;
                fired = 1'b1;
            end
            if (done_cnt > 0 && !busy) break;
        end
        start = 1'b0;
        check({tag, " completes"}, 64'(n < 20000), 64'd1);
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic verify_stream(input string tag, input int p, input int exp_busy);
        check({tag, " tx count"}, 64'(tx_q.size()), 64'd128);
        for (int k = 0; k < tx_q.size() && k < 128; k++)
            check($sformatf("%s byte%0d", tag, k), 64'(tx_q[k]), 64'(pat(p, k)));
        check({tag, " read count"}, 64'(rd_q.size()), 64'd32);
        for (int k = 0; k < rd_q.size() && k < 32; k++)
            check($sformatf("%s addr%0d", tag, k), 64'(rd_q[k]), 64'(4 * k));
        check({tag, " done pulses"}, 64'(done_cnt), 64'd1);
        check({tag, " busy cycles"}, 64'(busy_cycles), 64'(exp_busy));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " read_flag"}, 64'(bus.o_mem_read_flag), 64'd0);
        check({tag, " word_en"},   64'(bus.o_word_en),       64'd0);
        check({tag, " tx_start"},  64'(bus.o_tx_start),      64'd0);
        check({tag, " busy"},      64'(busy),                64'd0);
        check({tag, " done"},      64'(done),                64'd0);
        check({tag, " address"},   64'(bus.o_address),       64'd0);
        check({tag, " tx_data"},   64'(bus.o_tx_data),       64'd0);
    endtask

    vec_t vecs [4];

    initial begin
        int n;
        // {L, spurious done, restart byte, pattern, busy cycles = 32*(2+4*(1+L))+1}
        vecs[0] = '{1, 1'b0, -1, 0, 321};
        vecs[1] = '{2, 1'b1, -1, 1, 449};
        vecs[2] = '{1, 1'b0, 40, 0, 321};
        vecs[3] = '{3, 1'b1, 40, 1, 577};

        fill_mem(0);
        #1 rst_n = 1'b0;
        #2 check_reset_outputs("por");
        #10 rst_n = 1'b1;

        clear_mon();
        repeat (20) @(posedge clk);
        #1;
        check("idle tx count", 64'(tx_q.size()), 64'd0);
        check("idle read count", 64'(rd_q.size()), 64'd0);
        check("idle busy", 64'(busy_cycles), 64'd0);

        fill_mem(2);
        lat = 10;
        clear_mon();
        start_dump();
        wait_done("single", -1);
        verify_stream("single", 2, 1473);

        foreach (vecs[i]) begin
            fill_mem(vecs[i].pattern);
            lat = vecs[i].lat;
            spur_en = vecs[i].spur;
            clear_mon();
            start_dump();
            wait_done($sformatf("vec%0d", i), vecs[i].restart_at);
            verify_stream($sformatf("vec%0d", i), vecs[i].pattern, vecs[i].exp_busy);
        end

        fill_mem(0);
        lat = 1;
        spur_en = 1'b0;
        clear_mon();
        start_dump();
        for (n = 0; n < 2000; n++) begin
            @(posedge clk); #1;
            if (tx_q.size() >= 50) break;
        end
        check("reach byte 50", 64'(tx_q.size()), 64'd50);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("after reset tx count", 64'(tx_q.size()), 64'd50);
        check("after reset done", 64'(done_cnt), 64'd0);

        clear_mon();
        start_dump();
        wait_done("restart", -1);
        verify_stream("restart", 0, 321);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
